// File: rtl/redmule_pkg.sv
`default_nettype none
// ============================================================================
// Module   : redmule_pkg
// Purpose  : Shared TCDM response types and limits for the RedMulE memory
//            model and its users.
// Contents : TCDM_DW / TCDM_UW   default data / user widths
//            TCDM_RSP_MAX_LATENCY deepest supported read pipeline
//            tcdm_rsp_t           response beat {data, user, opc}
//            tcdm_clamp_latency   folds a latency into the legal 1..max range
// Revision : 1.0 - initial release
// ============================================================================
package redmule_pkg;

    localparam int TCDM_DW              = 288;
    localparam int TCDM_UW              = 1;
    localparam int TCDM_RSP_MAX_LATENCY = 4;

    typedef struct packed {
        logic [TCDM_DW-1:0] data;
        logic [TCDM_UW-1:0] user;
        logic               opc;
    } tcdm_rsp_t;

    function automatic int tcdm_clamp_latency(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > TCDM_RSP_MAX_LATENCY) begin
            return TCDM_RSP_MAX_LATENCY;
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/redmule_tcdm_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : redmule_tcdm_responder_if
// Purpose  : HCI core (TCDM) request/response bundle.
// Signals  : req/gnt handshake, add (byte address), wen (1 = read),
//            be (byte enables), data (write data), user (sideband);
//            r_valid/r_ready handshake, r_data, r_user (echo), r_opc (error).
// Modports : master = initiator (streamer), slave = memory target.
// Revision : 1.0 - initial release
// ============================================================================
interface redmule_tcdm_responder_if
    import redmule_pkg::*;
#(
    parameter int DW = TCDM_DW,
    parameter int AW = 32,
    parameter int UW = TCDM_UW
);

    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [UW-1:0]   user;

    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   r_data;
    logic [UW-1:0]   r_user;
    logic            r_opc;

    modport master (
        output req, add, wen, be, data, user, r_ready,
        input  gnt, r_valid, r_data, r_user, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, user, r_ready,
        output gnt, r_valid, r_data, r_user, r_opc
    );

endinterface
`default_nettype wire

// File: rtl/redmule_tcdm_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : redmule_tcdm_rsp_fifo
// Purpose  : Synchronous FIFO of TCDM response beats {data, user, opc}.
// Ports    : clk_i, rst_i (sync, active-high)
//            push_i + push_{data,user,opc}_i   enqueue (dropped when full)
//            pop_i                             dequeue (ignored when empty)
//            head_{data,user,opc}_o            oldest entry, valid if !empty_o
//            full_o, empty_o, count_o          occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module redmule_tcdm_rsp_fifo
    import redmule_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = TCDM_DW,
    parameter int UW    = TCDM_UW
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DW-1:0]                push_data_i,
    input  logic [UW-1:0]                push_user_i,
    input  logic                         push_opc_i,
    input  logic                         pop_i,
    output logic [DW-1:0]                head_data_o,
    output logic [UW-1:0]                head_user_o,
    output logic                         head_opc_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int              c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          opc;
    } rsp_t;

    rsp_t            r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are observed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{data: push_data_i, user: push_user_i, opc: push_opc_i};
        end
    end

    assign head_data_o = r_mem[r_rd_ptr].data;
    assign head_user_o = r_mem[r_rd_ptr].user;
    assign head_opc_o  = r_mem[r_rd_ptr].opc;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign count_o     = r_count;

endmodule
`default_nettype wire

// File: rtl/redmule_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : redmule_tcdm_responder
// Purpose  : TCDM target memory model: word array with byte-enable writes,
//            fixed-latency reads, credit-limited response FIFO.
// Ports    : clk_i, rst_i (sync, active-high)
//            stall_i        forces gnt low
//            tcdm (slave)   request/response bundle
//            oob_err_o      sticky out-of-range access flag
//            outstanding_o  reads in flight plus buffered responses
// Revision : 1.0 - initial release
// ============================================================================
module redmule_tcdm_responder
    import redmule_pkg::*;
#(
    parameter int DW         = TCDM_DW,
    parameter int AW         = 32,
    parameter int UW         = TCDM_UW,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              stall_i,
    redmule_tcdm_responder_if.slave           tcdm,
    output logic                              oob_err_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding_o
);

    localparam int              c_BYTES   = DW / 8;
    localparam int              c_OFFS    = $clog2(c_BYTES);
    localparam int              c_IW      = AW - c_OFFS;
    localparam int              c_MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW      = $clog2(FIFO_DEPTH + 1);
    localparam int              c_LAT     = tcdm_clamp_latency(LATENCY);
    localparam logic [c_CW-1:0] c_CREDITS = c_CW'(FIFO_DEPTH);
    localparam logic [63:0]     c_DEPTH_W = 64'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          opc;
    } rsp_t;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_CW-1:0] r_outstanding;
    logic            r_oob_err;
    rsp_t            r_last_rsp;

    logic [c_IW-1:0] w_idx;
    logic [c_MW-1:0] w_midx;
    logic            w_oob;
    logic            w_gnt;
    logic            w_rd_acc;
    logic            w_wr_acc;
    rsp_t            w_rd_rsp;
    logic            w_push;
    rsp_t            w_push_rsp;
    logic            w_pop;
    logic [DW-1:0]   w_head_data;
    logic [UW-1:0]   w_head_user;
    logic            w_head_opc;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_CW-1:0] w_fifo_count;
    logic            w_unused;

    // Low address bits select a byte inside the word and are ignored.
    assign w_idx  = tcdm.add[AW-1:c_OFFS];
    assign w_midx = w_idx[c_MW-1:0];
    assign w_oob  = (64'(w_idx) >= c_DEPTH_W);

    // Reads need a credit so every in-flight response has a FIFO slot waiting.
    assign w_gnt    = tcdm.req & ~stall_i & ~rst_i &
                      (tcdm.wen ? (r_outstanding < c_CREDITS) : 1'b1);
    assign w_rd_acc = w_gnt & tcdm.wen;
    assign w_wr_acc = w_gnt & ~tcdm.wen;

    always_ff @(posedge clk_i) begin
        if (w_wr_acc && !w_oob) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (tcdm.be[b]) begin
                    r_mem[w_midx][8*b +: 8] <= tcdm.data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_rsp      = '0;
        w_rd_rsp.data = w_oob ? '0 : r_mem[w_midx];
        w_rd_rsp.user = tcdm.user;
        w_rd_rsp.opc  = w_oob;
    end

    // LATENCY-1 register stages; the FIFO push edge supplies the last cycle.
    generate
        if (c_LAT == 1) begin : g_lat_direct
            assign w_push     = w_rd_acc;
            assign w_push_rsp = w_rd_rsp;
        end else begin : g_lat_pipe
            logic [c_LAT-2:0] r_pipe_vld;
            rsp_t             r_pipe_rsp [c_LAT-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_pipe_vld <= '0;
                end else begin
                    r_pipe_vld[0] <= w_rd_acc;
                    for (int i = 1; i < c_LAT - 1; i++) begin
                        r_pipe_vld[i] <= r_pipe_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                r_pipe_rsp[0] <= w_rd_rsp;
                for (int i = 1; i < c_LAT - 1; i++) begin
                    r_pipe_rsp[i] <= r_pipe_rsp[i-1];
                end
            end

            assign w_push     = r_pipe_vld[c_LAT-2];
            assign w_push_rsp = r_pipe_rsp[c_LAT-2];
        end
    endgenerate

    redmule_tcdm_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW),
        .UW    (UW)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_rsp.data),
        .push_user_i (w_push_rsp.user),
        .push_opc_i  (w_push_rsp.opc),
        .pop_i       (w_pop),
        .head_data_o (w_head_data),
        .head_user_o (w_head_user),
        .head_opc_o  (w_head_opc),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    assign w_pop = ~w_fifo_empty & tcdm.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CW'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_oob_err <= 1'b0;
        end else if (w_gnt && w_oob) begin
            r_oob_err <= 1'b1;
        end
    end

    // Shadow of the displayed head so the response bus keeps its last value
    // once the FIFO drains (the FIFO slot behind the head is stale).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_rsp <= '0;
        end else if (!w_fifo_empty) begin
            r_last_rsp <= '{data: w_head_data, user: w_head_user, opc: w_head_opc};
        end
    end

    assign tcdm.gnt     = w_gnt;
    assign tcdm.r_valid = ~w_fifo_empty;
    assign tcdm.r_data  = w_fifo_empty ? r_last_rsp.data : w_head_data;
    assign tcdm.r_user  = w_fifo_empty ? r_last_rsp.user : w_head_user;
    assign tcdm.r_opc   = w_fifo_empty ? r_last_rsp.opc  : w_head_opc;

    assign oob_err_o     = r_oob_err;
    assign outstanding_o = r_outstanding;

    assign w_unused = ^{tcdm.add[c_OFFS-1:0], w_fifo_full, w_fifo_count};

endmodule
`default_nettype wire
